ifetch_prefetch: RTL

Instruction-fetch prefetch buffer between a variable-latency instruction memory and the pipelined core's fetch stage. It takes the core's fetch address (PCF) and returns the instruction word (ImmRD) plus a valid flag. It prefetches sequential words into a small FIFO and flushes on any non-sequential PCF (branch/jump redirect). When ImmValid is low, the core must stall IF/ID.

---
 rtl/ifetch_prefetch_pkg.sv | 14 +
 rtl/ifetch_prefetch_fifo.sv | 50 +++++
 rtl/ifetch_prefetch.sv | 105 ++++++++++
 3 files changed

// File: rtl/ifetch_prefetch_pkg.sv
// Shared constants for the instruction-fetch prefetch buffer: default geometry,
// reset PC, word stride and the NOP value driven when no instruction is valid.
package ifetch_prefetch_pkg;

  localparam int          DEFAULT_DEPTH    = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] WORD_INC         = 32'd4;
  localparam logic [31:0] NOP              = 32'h0000_0000;

  function automatic logic [31:0] nextWord(input logic [31:0] addr);
    return addr + WORD_INC;
  endfunction

endpackage

// File: rtl/ifetch_prefetch_fifo.sv
// DEPTH x 32 synchronous FIFO holding prefetched instruction words.
// The head is read combinationally; flush empties it in one cycle.
module ifetch_prefetch_fifo
  import ifetch_prefetch_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   head_o,
  output logic [CW-1:0] count_o
);

  logic [31:0]   mem_q [DEPTH];
  logic [PW-1:0] rdPtr_q;
  logic [PW-1:0] wrPtr_q;
  logic [CW-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wrPtr_q <= wrPtr_q + PW'(1);
      if (pop_i)  rdPtr_q <= rdPtr_q + PW'(1);
      if (push_i && !pop_i)      count_q <= count_q + CW'(1);
      else if (pop_i && !push_i) count_q <= count_q - CW'(1);
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wrPtr_q] <= wdata_i;
  end

  assign head_o  = mem_q[rdPtr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ifetch_prefetch.sv
// Prefetch buffer between instruction memory and the core's fetch stage.
// Optional feature: define PREFETCH_BYPASS_EN to forward an ack straight to ImmRD when the FIFO is empty.
module ifetch_prefetch
  import ifetch_prefetch_pkg::*;
#(
  parameter int          DEPTH    = DEFAULT_DEPTH,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PCF,
  input  logic        StallF,
  output logic [31:0] ImmRD,
  output logic        ImmValid,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   expPc_q, expPc_d;
  logic [31:0]   fetchAddr_q, fetchAddr_d;
  logic [31:0]   memAddr_q, memAddr_d;
  logic          memReq_q, memReq_d;
  logic          stale_q, stale_d;

  logic [31:0]   fifoHead;
  logic [CW-1:0] count;
  logic [CW-1:0] countNext;
  logic [31:0]   fetchBase;
  logic          redirect, hit, pop, push, ackLive;
  logic          bypass, bypassTake, slotFree, issue;

  ifetch_prefetch_fifo #(.DEPTH(DEPTH)) uFifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect),
    .wdata_i (mem_rdata),
    .head_o  (fifoHead),
    .count_o (count)
  );

  always_comb begin
    redirect = (PCF != expPc_q);
    hit      = !redirect && (count != '0);
    ackLive  = mem_ack && !stale_q && !redirect;
`ifdef PREFETCH_BYPASS_EN
    bypass   = ackLive && (count == '0);
`else
    bypass   = 1'b0;
`endif
    bypassTake = bypass && !StallF;
    pop        = hit && !StallF;
    push       = ackLive && !bypassTake;

    ImmValid = hit || bypass;
    ImmRD    = hit ? fifoHead : (bypass ? mem_rdata : NOP);

    countNext = count;
    if (redirect)          countNext = '0;
    else if (push && !pop) countNext = count + CW'(1);
    else if (pop && !push) countNext = count - CW'(1);

    // One request at a time; the slot frees on the ack edge so issue can be back-to-back.
    slotFree  = !memReq_q || mem_ack;
    issue     = slotFree && (countNext < CW'(DEPTH));
    fetchBase = redirect ? PCF : fetchAddr_q;

    memReq_d    = issue ? 1'b1 : (mem_ack ? 1'b0 : memReq_q);
    memAddr_d   = issue ? fetchBase : memAddr_q;
    fetchAddr_d = issue ? nextWord(fetchBase) : fetchBase;

    expPc_d = expPc_q;
    if (redirect)                 expPc_d = PCF;
    else if (pop || bypassTake)   expPc_d = nextWord(expPc_q);

    stale_d = stale_q;
    if (mem_ack)                    stale_d = 1'b0;
    else if (redirect && memReq_q)  stale_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      expPc_q     <= RESET_PC;
      fetchAddr_q <= RESET_PC;
      memAddr_q   <= RESET_PC;
      memReq_q    <= 1'b0;
      stale_q     <= 1'b0;
    end else begin
      expPc_q     <= expPc_d;
      fetchAddr_q <= fetchAddr_d;
      memAddr_q   <= memAddr_d;
      memReq_q    <= memReq_d;
      stale_q     <= stale_d;
    end
  end

  assign mem_req  = memReq_q;
  assign mem_addr = memAddr_q;

endmodule
